// File: rtl/fsm_onehot_monitor.sv
// Receive-side checker/decoder for the 4-bit one-hot phase bus (S0..S3).
// Flags encoding and transition errors, decodes the phase and counts complete runs.
module fsm_onehot_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [3:0]       state_in_i,
  input  logic             clr_err_i,
  output logic [1:0]       phase_idx_o,
  output logic             busy_o,
  output logic             seq_done_o,
  output logic [CNT_W-1:0] seq_count_o,
  output logic             err_onehot_o,
  output logic             err_trans_o,
  output logic [1:0]       err_first_o
);

  localparam logic [3:0] S0 = 4'b0001;
  localparam logic [3:0] S1 = 4'b0010;
  localparam logic [3:0] S2 = 4'b0100;
  localparam logic [3:0] S3 = 4'b1000;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_ONEHOT = 2'b01,
    ERR_TRANS  = 2'b10
  } err_code_e;

  logic [3:0]       prevState_q, prevState_d;
  logic             prevValid_q, prevValid_d;
  logic             runOk_q, runOk_d;
  logic [1:0]       phaseIdx_q, phaseIdx_d;
  logic             busy_q, busy_d;
  logic             seqDone_q, seqDone_d;
  logic [CNT_W-1:0] seqCount_q, seqCount_d;
  logic             errOnehot_q, errOnehot_d;
  logic             errTrans_q, errTrans_d;
  err_code_e        errFirst_q, errFirst_d;

  logic       isOneHot;
  logic       legalStep;
  logic       onehotErr;
  logic       transErr;
  logic [1:0] sampleIdx;

  always_comb begin
    isOneHot  = (state_in_i != 4'd0) && ((state_in_i & (state_in_i - 4'd1)) == 4'd0);

    sampleIdx = 2'd0;
    case (state_in_i)
      S1:      sampleIdx = 2'd1;
      S2:      sampleIdx = 2'd2;
      S3:      sampleIdx = 2'd3;
      default: sampleIdx = 2'd0;
    endcase

    legalStep = 1'b0;
    case (prevState_q)
      S0:      legalStep = (state_in_i == S0) || (state_in_i == S1);
      S1:      legalStep = (state_in_i == S2);
      S2:      legalStep = (state_in_i == S3);
      S3:      legalStep = (state_in_i == S0);
      default: legalStep = 1'b0;
    endcase
  end

  always_comb begin
    prevState_d = prevState_q;
    prevValid_d = prevValid_q;
    runOk_d     = runOk_q;
    phaseIdx_d  = phaseIdx_q;
    busy_d      = busy_q;
    seqDone_d   = 1'b0;
    seqCount_d  = seqCount_q;
    onehotErr   = 1'b0;
    transErr    = 1'b0;

    if (!isOneHot) begin
      onehotErr   = 1'b1;
      prevValid_d = 1'b0;
      runOk_d     = 1'b0;
    end else begin
      phaseIdx_d  = sampleIdx;
      busy_d      = (state_in_i != S0);
      prevState_d = state_in_i;
      prevValid_d = 1'b1;
      // The first valid sample after reset or a bad encoding only resyncs.
      if (prevValid_q) begin
        if (!legalStep) begin
          transErr = 1'b1;
          runOk_d  = 1'b0;
        end else if (prevState_q == S0 && state_in_i == S1) begin
          runOk_d = 1'b1;
        end else if (prevState_q == S3 && state_in_i == S0) begin
          seqDone_d = runOk_q;
          runOk_d   = 1'b0;
        end
      end
    end

    if (seqDone_d && (seqCount_q != {CNT_W{1'b1}})) begin
      seqCount_d = seqCount_q + CNT_W'(1);
    end

    // A clear and a fresh error on the same edge: the fresh error survives.
    errOnehot_d = clr_err_i ? 1'b0 : errOnehot_q;
    errTrans_d  = clr_err_i ? 1'b0 : errTrans_q;
    errFirst_d  = clr_err_i ? ERR_NONE : errFirst_q;
    if (onehotErr) errOnehot_d = 1'b1;
    if (transErr)  errTrans_d  = 1'b1;
    if (errFirst_d == ERR_NONE) begin
      if (onehotErr)     errFirst_d = ERR_ONEHOT;
      else if (transErr) errFirst_d = ERR_TRANS;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prevState_q <= S0;
      prevValid_q <= 1'b0;
      runOk_q     <= 1'b0;
      phaseIdx_q  <= 2'd0;
      busy_q      <= 1'b0;
      seqDone_q   <= 1'b0;
      seqCount_q  <= '0;
      errOnehot_q <= 1'b0;
      errTrans_q  <= 1'b0;
      errFirst_q  <= ERR_NONE;
    end else begin
      prevState_q <= prevState_d;
      prevValid_q <= prevValid_d;
      runOk_q     <= runOk_d;
      phaseIdx_q  <= phaseIdx_d;
      busy_q      <= busy_d;
      seqDone_q   <= seqDone_d;
      seqCount_q  <= seqCount_d;
      errOnehot_q <= errOnehot_d;
      errTrans_q  <= errTrans_d;
      errFirst_q  <= errFirst_d;
    end
  end

  assign phase_idx_o  = phaseIdx_q;
  assign busy_o       = busy_q;
  assign seq_done_o   = seqDone_q;
  assign seq_count_o  = seqCount_q;
  assign err_onehot_o = errOnehot_q;
  assign err_trans_o  = errTrans_q;
  assign err_first_o  = errFirst_q;

endmodule

// File: tb/tb_fsm_onehot_monitor.sv
// Self-checking bench for fsm_onehot_monitor: a sample-history model checked every
// cycle, plus directed sequences with hand-computed literal expectations.
module tb_fsm_onehot_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] stateIn = 4'b0001;
  logic       clrErr = 1'b0;

  logic [1:0] phaseIdx, phaseIdxS;
  logic       busy, busyS, seqDone, seqDoneS;
  logic [7:0] seqCount;
  logic [1:0] seqCountS;
  logic       errOnehot, errOnehotS, errTrans, errTransS;
  logic [1:0] errFirst, errFirstS;

  int total = 0;
  int bad = 0;
  bit checkOn = 1'b0;

  fsm_onehot_monitor dut (
    .clk_i(clk), .reset_i(reset), .state_in_i(stateIn), .clr_err_i(clrErr),
    .phase_idx_o(phaseIdx), .busy_o(busy), .seq_done_o(seqDone),
    .seq_count_o(seqCount), .err_onehot_o(errOnehot), .err_trans_o(errTrans),
    .err_first_o(errFirst)
  );

  fsm_onehot_monitor #(.CNT_W(2)) dutSat (
    .clk_i(clk), .reset_i(reset), .state_in_i(stateIn), .clr_err_i(clrErr),
    .phase_idx_o(phaseIdxS), .busy_o(busyS), .seq_done_o(seqDoneS),
    .seq_count_o(seqCountS), .err_onehot_o(errOnehotS), .err_trans_o(errTransS),
    .err_first_o(errFirstS)
  );

  always #5 clk = ~clk;

  // Model: remembers the recent sample history and derives outputs from it.
  logic [3:0] win[$];
  logic [3:0] mPrev = 4'b0001;
  bit         mHavePrev = 1'b0;
  int         mPhase = 0, mBusy = 0, mDone = 0, mCount = 0, mCountS = 0;
  int         mErrOh = 0, mErrTr = 0, mFirst = 0;

  function automatic int bitIndex(input logic [3:0] s);
    int r = 0;
    for (int b = 0; b < 4; b++) if (s[b]) r = b;
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      win.delete();
      mHavePrev = 1'b0; mPrev = 4'b0001;
      mPhase = 0; mBusy = 0; mDone = 0; mCount = 0; mCountS = 0;
      mErrOh = 0; mErrTr = 0; mFirst = 0;
    end else begin
      logic [3:0] s;
      bit oh, eO, eT, runMatch;
      logic [3:0] runPat[5];
      runPat = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      s  = stateIn;
      oh = ($countones(s) == 1);
      eO = !oh;
      eT = 1'b0;
      if (oh) begin
        int i, j;
        i = bitIndex(s);
        if (mHavePrev) begin
          j = bitIndex(mPrev);
          eT = !((i == (j + 1) % 4) || (i == 0 && j == 0));
        end
        mPhase = i; mBusy = (i != 0); mPrev = s; mHavePrev = 1'b1;
      end else begin
        mHavePrev = 1'b0;
      end
      win.push_back(s);
      if (win.size() > 5) void'(win.pop_front());
      runMatch = (win.size() == 5);
      if (runMatch) for (int k = 0; k < 5; k++) if (win[k] != runPat[k]) runMatch = 1'b0;
      mDone = runMatch;
      if (runMatch) begin
        if (mCount < 255) mCount++;
        if (mCountS < 3) mCountS++;
      end
      if (clrErr) begin mErrOh = 0; mErrTr = 0; mFirst = 0; end
      if (eO) mErrOh = 1;
      if (eT) mErrTr = 1;
      if (mFirst == 0) mFirst = eO ? 1 : (eT ? 2 : 0);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("m_phase_idx", int'(phaseIdx), mPhase);
      checkOutput("m_busy", int'(busy), mBusy);
      checkOutput("m_seq_done", int'(seqDone), mDone);
      checkOutput("m_seq_count", int'(seqCount), mCount);
      checkOutput("m_seq_count_sat", int'(seqCountS), mCountS);
      checkOutput("m_err_onehot", int'(errOnehot), mErrOh);
      checkOutput("m_err_trans", int'(errTrans), mErrTr);
      checkOutput("m_err_first", int'(errFirst), mFirst);
    end
  end

  task automatic applyStimulus(input logic [3:0] s, input logic clr);
    stateIn = s;
    clrErr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_phase"}, int'(phaseIdx), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(seqDone), 0);
    checkOutput({tag, "_count"}, int'(seqCount), 0);
    checkOutput({tag, "_erroh"}, int'(errOnehot), 0);
    checkOutput({tag, "_errtr"}, int'(errTrans), 0);
    checkOutput({tag, "_first"}, int'(errFirst), 0);
  endtask

  initial begin
    logic [3:0] runVec[4];
    int pulses, lastPulse, cyc;
    runVec = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    #1 reset = 1'b1;
    checkOn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    // Idle in S0, then one complete run.
    repeat (3) applyStimulus(4'b0001, 1'b0);
    checkOutput("t1_phase_s0", int'(phaseIdx), 0);
    checkOutput("t1_busy_s0", int'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(runVec[k], 1'b0);
      checkOutput("t1_phase", int'(phaseIdx), (k + 1) % 4);
      checkOutput("t1_done", int'(seqDone), (k == 3) ? 1 : 0);
    end
    checkOutput("t1_count", int'(seqCount), 1);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("t1_done_pulse", int'(seqDone), 0);
    checkOutput("t1_no_err", int'(errOnehot | errTrans), 0);

    // Back-to-back runs: pulses exactly 4 cycles apart.
    pulses = 0; lastPulse = -1; cyc = 0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        applyStimulus(runVec[k], 1'b0);
        cyc++;
        if (seqDone) begin
          if (lastPulse >= 0) checkOutput("t2_gap", cyc - lastPulse, 4);
          lastPulse = cyc;
          pulses++;
        end
      end
    end
    checkOutput("t2_pulses", pulses, 3);
    checkOutput("t2_count", int'(seqCount), 4);
    checkOutput("t2_count_sat", int'(seqCountS), 3);
    for (int r = 0; r < 8; r++) for (int k = 0; k < 4; k++) applyStimulus(runVec[k], 1'b0);
    checkOutput("t2_count12", int'(seqCount), 12);
    checkOutput("t2_sat_hold", int'(seqCountS), 3);

    // Bad encoding mid-run.
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b0110, 1'b0);
    checkOutput("t3_erroh", int'(errOnehot), 1);
    checkOutput("t3_first", int'(errFirst), 1);
    checkOutput("t3_phase_hold", int'(phaseIdx), 1);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("t3_resync", int'(errTrans), 0);
    checkOutput("t3_phase3", int'(phaseIdx), 3);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("t3_no_done", int'(seqDone), 0);
    checkOutput("t3_count", int'(seqCount), 12);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("t3_clr", int'(errOnehot) + int'(errTrans) + int'(errFirst), 0);

    // Dwell in S1 is an illegal transition and kills the run.
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("t4_errtr", int'(errTrans), 1);
    checkOutput("t4_first", int'(errFirst), 2);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b1000, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("t4_no_done", int'(seqDone), 0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("t4_clr", int'(errOnehot) + int'(errTrans) + int'(errFirst), 0);

    // Clear and a new error on the same edge.
    applyStimulus(4'b0100, 1'b0);
    checkOutput("t5_errtr", int'(errTrans), 1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t5_erroh", int'(errOnehot), 1);
    checkOutput("t5_errtr_clr", int'(errTrans), 0);
    checkOutput("t5_first", int'(errFirst), 1);
    applyStimulus(4'b0001, 1'b1);

    // Asynchronous reset mid-run, then resync on S3.
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkAllZero("t6_async");
    stateIn = 4'b1000;
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(4'b1000, 1'b0);
    checkOutput("t6_phase3", int'(phaseIdx), 3);
    checkOutput("t6_resync", int'(errTrans), 0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("t6_no_errtr", int'(errTrans), 0);
    checkOutput("t6_no_done", int'(seqDone), 0);
    checkOutput("t6_count", int'(seqCount), 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_onehot_monitor.md
Name: fsm_onehot_monitor

Overview:
- Receive-side checker and decoder for the 4-bit one-hot phase bus driven by the start-triggered phase sequencer (S0=0001, S1=0010, S2=0100, S3=1000).
- Samples the bus every clock and checks the one-hot encoding and the phase-to-phase transitions.
- Produces the binary phase index, a busy flag, a completed-sequence pulse and a saturating sequence counter.
- Sits beside the sequencer in the control path; its outputs feed status registers and assertion logic.

Parameters:
- CNT_W, 8, width of seq_count; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- state_in  input  4  one-hot phase bus from the sequencer.
- clr_err  input  1  synchronous clear of the sticky error flags and err_first.
- phase_idx  output  2  registered binary decode of the last legally encoded sample (S0=0 … S3=3).
- busy  output  1  registered; 1 when the last legally encoded sample was S1, S2 or S3.
- seq_done  output  1  one-cycle pulse marking a complete, error-free S0→S1→S2→S3→S0 run.
- seq_count  output  CNT_W  saturating count of seq_done pulses.
- err_onehot  output  1  sticky; a sample was not exactly one-hot.
- err_trans  output  1  sticky; an illegal transition was sampled.
- err_first  output  2  code of the first error since reset or clear: 00 none, 01 one-hot, 10 transition.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0. Internal prev_state=0001, prev_valid=0, run_ok=0. Reset asserted mid-run drops the run; no seq_done is produced for it.
- Timing: state_in is sampled on every rising clk edge. All outputs are registered and reflect the sample taken at edge k immediately after edge k (1-cycle latency).
- Encoding check: popcount(state_in)≠1 (includes 0000) → set err_onehot.
  - prev_valid←0 and run_ok←0.
  - phase_idx and busy hold their previous values.
  - No transition check on this sample.
- Valid sample (exactly one-hot):
  - phase_idx and busy update.
  - prev_state←state_in; prev_valid←1.
- Transition check: performed only when prev_valid=1 and the current sample is one-hot. Legal transitions:
  - S0→S0
  - S0→S1
  - S1→S2
  - S2→S3
  - S3→S0
- Illegal transition (including any dwell in S1/S2/S3): set err_trans and clear run_ok. Phase outputs still update to the new sample.
- Resync: the first valid sample after reset or after a bad encoding only establishes prev_state; it is never flagged as a transition error.
- run_ok:
  - Set by a legal S0→S1.
  - Cleared by any error and by reset.
  - Cleared on S3→S0 after that transition is evaluated.
- seq_done: asserted for one cycle after the edge that samples a legal S3→S0 while run_ok=1; otherwise 0. Back-to-back runs (S3→S0→S1 …) are supported; a seq_done pulse can occur every 4 cycles.
- seq_count: increments by 1 on each seq_done and holds at all-ones (saturates, no wrap).
- err_first:
  - Loaded only while it equals 00, with the code of the error detected at that edge.
  - The one-hot and transition errors cannot both occur on one sample.
- clr_err: at the edge where clr_err=1, err_onehot, err_trans and err_first clear to 0. If an error is detected at the same edge, the new error wins: its flag is set and err_first takes its code. clr_err does not affect seq_count, run_ok or prev_state.
- No other state; no combinational path from input to output.

Test Plan:
- Reset, then 0001 for 3 cycles, then 0010,0100,1000,0001 → seq_done high exactly one cycle after the final 0001 sample; seq_count=1; phase_idx sequence 0,1,2,3,0; no errors.
- Three back-to-back runs (0001,0010,0100,1000 repeated, ending 0001) → three seq_done pulses 4 cycles apart; seq_count=3. With CNT_W=2, eight runs → seq_count holds at 3.
- Sample 0110 mid-run (between 0010 and 1000) → err_onehot=1, err_first=01, phase_idx holds 1; the following 1000 is not flagged; the next 0001 gives no seq_done.
- Sample 0010 twice in a row → err_trans=1, err_first=10 and no seq_done for that run. Then assert clr_err alone → all error flags 0 the next cycle.
- clr_err=1 on the same edge as a 0000 sample → err_onehot=1, err_first=01 after the edge.
- Assert reset asynchronously mid-run while the bus is at 0100 → all outputs 0 immediately. Deassert with the bus at 1000, then 0001 → no err_trans (resync) and no seq_done.
